// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite AR/R/AW/W/B bundle between the load/store master and the memory responder.
// The slave modport is the responder's view; the master modport drives requests.
interface axi_lite_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid,
    output awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid,
    input  awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory responder: byte-strobed word array behind independent read and
// write FSMs, each with a programmable response latency; out-of-range answers SLVERR.
module axi_lite_mem_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE       = 32'h8000_0000,
  parameter int                    DEPTH      = 1024,
  parameter int                    LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_lite_mem_slave_if.slave  bus
);

  localparam int                  STRB_W = DATA_WIDTH / 8;
  localparam int                  IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN   = (ADDR_WIDTH+1)'(DEPTH * 8);
  localparam logic [3:0]          LAT    = 4'(LATENCY);
  localparam logic [1:0]          RESP_OKAY   = 2'b00;
  localparam logic [1:0]          RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE;
    return (a >= BASE) && ({1'b0, off} < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = (a - BASE) >> 3;
    return IDX_W'(off);
  endfunction

  // ---------------------------------------------------------------- state
  logic                  out_en_reg;

  r_state_t              r_state_reg, r_state_next;
  logic [3:0]            r_cnt_reg, r_cnt_next;
  logic [ADDR_WIDTH-1:0] ar_addr_reg, ar_addr_next;
  logic                  r_capture;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]            rresp_reg;

  w_state_t              w_state_reg, w_state_next;
  logic [3:0]            w_cnt_reg, w_cnt_next;
  logic [ADDR_WIDTH-1:0] aw_addr_reg, aw_addr_next;
  logic [DATA_WIDTH-1:0] w_data_reg, w_data_next;
  logic [STRB_W-1:0]     w_strb_reg, w_strb_next;
  logic                  aw_done_reg, aw_done_next;
  logic                  w_done_reg, w_done_next;
  logic                  w_commit;
  logic [1:0]            bresp_reg;

  logic                  r_hit, w_hit;
  logic [IDX_W-1:0]      r_idx, w_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  aw_fire, w_fire;

  assign r_hit = addr_in_range(ar_addr_reg);
  assign r_idx = addr_index(ar_addr_reg);
  assign w_hit = addr_in_range(aw_addr_reg);
  assign w_idx = addr_index(aw_addr_reg);

  // ---------------------------------------------------------------- outputs
  // out_en_reg keeps every ready low while reset is held and until the first edge after.
  assign bus.arready = out_en_reg && (r_state_reg == R_IDLE);
  assign bus.rvalid  = (r_state_reg == R_RESP);
  assign bus.rdata   = rdata_reg;
  assign bus.rresp   = rresp_reg;
  assign bus.awready = out_en_reg && (w_state_reg == W_IDLE) && !aw_done_reg;
  assign bus.wready  = out_en_reg && (w_state_reg == W_IDLE) && !w_done_reg;
  assign bus.bvalid  = (w_state_reg == W_RESP);
  assign bus.bresp   = bresp_reg;

  assign aw_fire = bus.awvalid && bus.awready;
  assign w_fire  = bus.wvalid && bus.wready;

  // ---------------------------------------------------------------- memory
  // One byte-wide array per strobe lane so each lane is an independent write enable.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (w_commit && w_hit && w_strb_reg[gi]) begin
          mem[w_idx] <= w_data_reg[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = mem[r_idx];
    end
  endgenerate

  // ---------------------------------------------------------------- read FSM
  always_comb begin
    r_state_next = r_state_reg;
    r_cnt_next   = r_cnt_reg;
    ar_addr_next = ar_addr_reg;
    r_capture    = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        if (bus.arvalid && out_en_reg) begin
          ar_addr_next = bus.araddr;
          r_cnt_next   = LAT;
          r_state_next = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt_reg == 4'd0) begin
          r_capture    = 1'b1;
          r_state_next = R_RESP;
        end else begin
          r_cnt_next = r_cnt_reg - 4'd1;
        end
      end
      R_RESP: begin
        if (bus.rready) begin
          r_state_next = R_IDLE;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // Capture shares the edge with any write commit, so a same-word read sees old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_en_reg  <= 1'b0;
      r_state_reg <= R_IDLE;
      r_cnt_reg   <= '0;
      ar_addr_reg <= '0;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
    end else begin
      out_en_reg  <= 1'b1;
      r_state_reg <= r_state_next;
      r_cnt_reg   <= r_cnt_next;
      ar_addr_reg <= ar_addr_next;
      if (r_capture) begin
        rdata_reg <= r_hit ? rd_word : '0;
        rresp_reg <= r_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // ---------------------------------------------------------------- write FSM
  always_comb begin
    w_state_next = w_state_reg;
    w_cnt_next   = w_cnt_reg;
    aw_addr_next = aw_addr_reg;
    w_data_next  = w_data_reg;
    w_strb_next  = w_strb_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    w_commit     = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        if (aw_fire) begin
          aw_addr_next = bus.awaddr;
          aw_done_next = 1'b1;
        end
        if (w_fire) begin
          w_data_next = bus.wdata;
          w_strb_next = bus.wstrb;
          w_done_next = 1'b1;
        end
        // The latency count starts on the edge that completes the AW/W pair.
        if (aw_done_next && w_done_next) begin
          w_cnt_next   = LAT;
          w_state_next = W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_cnt_reg == 4'd0) begin
          w_commit     = 1'b1;
          w_state_next = W_RESP;
        end else begin
          w_cnt_next = w_cnt_reg - 4'd1;
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_reg <= W_IDLE;
      w_cnt_reg   <= '0;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      w_state_reg <= w_state_next;
      w_cnt_reg   <= w_cnt_next;
      aw_addr_reg <= aw_addr_next;
      w_data_reg  <= w_data_next;
      w_strb_reg  <= w_strb_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      if (w_commit) begin
        bresp_reg <= w_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench for axi_lite_mem_slave: reset, latency, strobes, range errors,
// channel ordering, backpressure, read-before-write and mid-transaction reset.
module tb_axi_lite_mem_slave;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  axi_lite_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

  axi_lite_mem_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(64),
    .BASE      (32'h8000_0000),
    .DEPTH     (1024),
    .LATENCY   (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues AW and W together; lat = cycles from the accepting edge to bvalid (-1 on timeout).
  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          output logic [1:0] resp, output int lat);
    int   guard;
    logic at, wt;
    guard = 0;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    while ((bus.awvalid || bus.wvalid) && guard < 50) begin
      at = bus.awvalid && bus.awready;
      wt = bus.wvalid && bus.wready;
      tick;
      if (at) bus.awvalid = 1'b0;
      if (wt) bus.wvalid = 1'b0;
      guard++;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick;
      if (bus.bvalid) begin lat = k; break; end
    end
    resp = bus.bresp;
    if (bus.bvalid) begin
      bus.bready = 1'b1; tick; bus.bready = 1'b0;
    end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp,
                         output int lat);
    int   guard;
    logic at;
    guard = 0;
    bus.araddr = a; bus.arvalid = 1'b1;
    while (bus.arvalid && guard < 50) begin
      at = bus.arready;
      tick;
      if (at) bus.arvalid = 1'b0;
      guard++;
    end
    bus.arvalid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick;
      if (bus.rvalid) begin lat = k; break; end
    end
    d = bus.rdata; resp = bus.rresp;
    if (bus.rvalid) begin
      bus.rready = 1'b1; tick; bus.rready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.arvalid = 1'b1;
    repeat (3) tick;
    n_cmp++; if (bus.arready !== 1'b0) begin n_bad++; $display("FAIL reset_arready: got %b want 0", bus.arready); end
    n_cmp++; if (bus.rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", bus.rvalid); end
    n_cmp++; if (bus.bvalid !== 1'b0) begin n_bad++; $display("FAIL reset_bvalid: got %b want 0", bus.bvalid); end
    n_cmp++; if ({bus.awready, bus.wready} !== 2'b00) begin n_bad++; $display("FAIL reset_aw_w_ready: got %b want 00", {bus.awready, bus.wready}); end
    n_cmp++; if ({bus.rdata, bus.rresp, bus.bresp} !== 68'h0) begin n_bad++; $display("FAIL reset_data_resp: got %h want 0", {bus.rdata, bus.rresp, bus.bresp}); end
    bus.arvalid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.arready !== 1'b0) begin n_bad++; $display("FAIL release_before_edge_arready: got %b want 0", bus.arready); end
    tick;
    n_cmp++; if ({bus.arready, bus.awready, bus.wready} !== 3'b111) begin n_bad++; $display("FAIL release_readies: got %b want 111", {bus.arready, bus.awready, bus.wready}); end
    $display("reset: readies=%b after release", {bus.arready, bus.awready, bus.wready});
  endtask

  task automatic test_write_read;
    logic [1:0]  resp;
    logic [63:0] d;
    int          lat;
    do_write(32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, resp, lat);
    $display("write 80000008 data=1122334455667788 strb=ff bresp=%b lat=%0d", resp, lat);
    n_cmp++; if (lat !== LAT + 1) begin n_bad++; $display("FAIL write_latency: got %0d want %0d", lat, LAT + 1); end
    n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL write_bresp: got %b want 00", resp); end
    do_read(32'h8000_0008, d, resp, lat);
    $display("read 80000008 rdata=%h rresp=%b lat=%0d", d, resp, lat);
    n_cmp++; if (d !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL read_data: got %h want 1122334455667788", d); end
    n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL read_rresp: got %b want 00", resp); end
    n_cmp++; if (lat !== LAT + 1) begin n_bad++; $display("FAIL read_latency: got %0d want %0d", lat, LAT + 1); end
  endtask

  task automatic test_partial_strobe;
    logic [1:0]  resp;
    logic [63:0] d;
    int          lat;
    do_write(32'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, resp, lat);
    do_write(32'h8000_0010, 64'h0, 8'h0F, resp, lat);
    do_read(32'h8000_0010, d, resp, lat);
    $display("strobe 0f write of 0 over all-ones: rdata=%h", d);
    n_cmp++; if (d !== 64'hFFFF_FFFF_0000_0000) begin n_bad++; $display("FAIL strobe_0f: got %h want ffffffff00000000", d); end
    do_write(32'h8000_0010, 64'h1234_5678_9ABC_DEF0, 8'h00, resp, lat);
    $display("strobe 00 write: bresp=%b", resp);
    n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL strobe_00_bresp: got %b want 00", resp); end
    do_read(32'h8000_0010, d, resp, lat);
    n_cmp++; if (d !== 64'hFFFF_FFFF_0000_0000) begin n_bad++; $display("FAIL strobe_00_data: got %h want ffffffff00000000", d); end
  endtask

  task automatic test_out_of_range;
    logic [1:0]  resp;
    logic [63:0] d;
    int          lat;
    do_write(32'h8000_0000, 64'h0BAD_F00D_CAFE_0001, 8'hFF, resp, lat);
    do_read(32'h7FFF_FFF8, d, resp, lat);
    $display("read 7ffffff8 rdata=%h rresp=%b", d, resp);
    n_cmp++; if (resp !== 2'b10) begin n_bad++; $display("FAIL oor_read_rresp: got %b want 10", resp); end
    n_cmp++; if (d !== 64'h0) begin n_bad++; $display("FAIL oor_read_data: got %h want 0", d); end
    do_write(32'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, resp, lat);
    $display("write 80002000 bresp=%b lat=%0d", resp, lat);
    n_cmp++; if (resp !== 2'b10) begin n_bad++; $display("FAIL oor_write_bresp: got %b want 10", resp); end
    do_read(32'h8000_0000, d, resp, lat);
    n_cmp++; if (d !== 64'h0BAD_F00D_CAFE_0001) begin n_bad++; $display("FAIL oor_word0_intact: got %h want 0badf00dcafe0001", d); end
  endtask

  // aw_at / w_at are the cycle offsets at which each channel is presented.
  task automatic test_channel_order(input int aw_at, input int w_at, input logic [63:0] d_in);
    int          last, lat, bad;
    logic [1:0]  resp;
    logic [63:0] d;
    last = (aw_at > w_at) ? aw_at : w_at;
    bad  = 0;
    for (int c = 0; c <= last; c++) begin
      if (c == aw_at) begin bus.awaddr = 32'h8000_0030; bus.awvalid = 1'b1; end
      if (c == w_at) begin bus.wdata = d_in; bus.wstrb = 8'hFF; bus.wvalid = 1'b1; end
      tick;
      if (c == aw_at) bus.awvalid = 1'b0;
      if (c == w_at) bus.wvalid = 1'b0;
      if (c < last) begin
        if (c >= w_at && bus.wready) bad++;
        if (c >= aw_at && bus.awready) bad++;
        if (bus.bvalid) bad++;
      end
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick;
      if (bus.bvalid) begin lat = k; break; end
    end
    resp = bus.bresp;
    if (bus.bvalid) begin bus.bready = 1'b1; tick; bus.bready = 1'b0; end
    do_read(32'h8000_0030, d, resp, lat == -1 ? last : last);
    $display("order aw_at=%0d w_at=%0d: bvalid lat=%0d early_ready=%0d rdata=%h", aw_at, w_at, lat, bad, d);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL order_ready_drop aw_at=%0d w_at=%0d: got %0d violations want 0", aw_at, w_at, bad); end
    n_cmp++; if (lat !== LAT + 1) begin n_bad++; $display("FAIL order_latency aw_at=%0d w_at=%0d: got %0d want %0d", aw_at, w_at, lat, LAT + 1); end
    n_cmp++; if (d !== d_in) begin n_bad++; $display("FAIL order_data aw_at=%0d w_at=%0d: got %h want %h", aw_at, w_at, d, d_in); end
  endtask

  task automatic test_backpressure;
    int          lat, bad;
    logic [63:0] d0;
    bad = 0;
    bus.araddr = 32'h8000_0008; bus.arvalid = 1'b1;
    tick;
    bus.arvalid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick;
      if (bus.rvalid) begin lat = k; break; end
    end
    d0 = bus.rdata;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (!bus.rvalid || bus.rdata !== 64'h1122_3344_5566_7788 || bus.arready) bad++;
    end
    $display("backpressure: lat=%0d rdata=%h unstable_cycles=%0d", lat, d0, bad);
    n_cmp++; if (lat !== LAT + 1) begin n_bad++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT + 1); end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
    bus.rready = 1'b1; tick; bus.rready = 1'b0;
    n_cmp++; if ({bus.arready, bus.rvalid} !== 2'b10) begin n_bad++; $display("FAIL bp_after_rready: got arready,rvalid=%b want 10", {bus.arready, bus.rvalid}); end
  endtask

  task automatic test_concurrent_rbw;
    logic [1:0]  wresp, rresp;
    logic [63:0] d;
    int          wlat, rlat;
    do_write(32'h8000_0018, 64'h0000_0000_0000_00AA, 8'hFF, wresp, wlat);
    fork
      do_write(32'h8000_0018, 64'h5555_6666_7777_8888, 8'hFF, wresp, wlat);
      do_read(32'h8000_0018, d, rresp, rlat);
    join
    $display("concurrent word3: read=%h rlat=%0d wlat=%0d", d, rlat, wlat);
    n_cmp++; if (rlat !== wlat || rlat !== LAT + 1) begin n_bad++; $display("FAIL rbw_same_edge: got rlat=%0d wlat=%0d want %0d", rlat, wlat, LAT + 1); end
    n_cmp++; if (d !== 64'h0000_0000_0000_00AA) begin n_bad++; $display("FAIL rbw_old_data: got %h want 00000000000000aa", d); end
    do_read(32'h8000_0018, d, rresp, rlat);
    $display("read word3 after commit: %h", d);
    n_cmp++; if (d !== 64'h5555_6666_7777_8888) begin n_bad++; $display("FAIL rbw_new_data: got %h want 5555666677778888", d); end
  endtask

  task automatic test_reset_mid_transaction;
    logic [1:0]  resp;
    logic [63:0] d;
    int          lat;
    do_write(32'h8000_0028, 64'hA5A5_0000_1234_5678, 8'hFF, resp, lat);
    bus.araddr = 32'h8000_0028; bus.arvalid = 1'b1;
    tick;
    bus.arvalid = 1'b0;
    repeat (LAT + 1) tick;
    rst = 1'b0;
    #1;
    $display("reset during R_RESP: rvalid=%b rdata=%h", bus.rvalid, bus.rdata);
    n_cmp++; if ({bus.rvalid, bus.arready} !== 2'b00) begin n_bad++; $display("FAIL mid_reset_rvalid: got rvalid,arready=%b want 00", {bus.rvalid, bus.arready}); end
    n_cmp++; if (bus.rdata !== 64'h0) begin n_bad++; $display("FAIL mid_reset_rdata: got %h want 0", bus.rdata); end
    rst = 1'b1;
    tick;
    bus.awaddr = 32'h8000_0028; bus.wdata = 64'hFFFF_EEEE_DDDD_CCCC; bus.wstrb = 8'hFF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    tick;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick;
    rst = 1'b0;
    #1;
    n_cmp++; if ({bus.bvalid, bus.awready, bus.wready} !== 3'b000) begin n_bad++; $display("FAIL mid_reset_write_outputs: got %b want 000", {bus.bvalid, bus.awready, bus.wready}); end
    repeat (4) tick;
    rst = 1'b1;
    tick;
    do_read(32'h8000_0028, d, resp, lat);
    $display("read word5 after abandoned write: %h", d);
    n_cmp++; if (d !== 64'hA5A5_0000_1234_5678) begin n_bad++; $display("FAIL mid_reset_no_commit: got %h want a5a5000012345678", d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0;
    test_reset;
    test_write_read;
    test_partial_strobe;
    test_out_of_range;
    test_channel_order(4, 0, 64'h0102_0304_0506_0708);
    test_channel_order(0, 4, 64'h1111_2222_3333_4444);
    test_channel_order(0, 0, 64'hCAFE_BABE_0000_FFFF);
    test_backpressure;
    test_concurrent_rbw;
    test_reset_mid_transaction;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_slave.md
# axi_lite_mem_slave

AXI4-Lite responder memory model: the target side of the memory-access path, accepting read and write transactions from the load/store unit's AXI-Lite master and serving them from an internal word array. It is 64-bit wide with byte strobes and has a programmable response latency to emulate real memory. Out-of-range addresses are answered with SLVERR. It sits behind the crossbar, at the far end of the AR/R/AW/W/B channels.

## Interface
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 64, data bus width; fixed 64, giving 8 strobe bits
- BASE, 32'h80000000, byte address of word 0
- DEPTH, 1024, number of 64-bit words
- LATENCY, 2, wait cycles between address acceptance and response (0..15)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- araddr  in  32  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  64  read data
- rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  32  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  64  write data
- wstrb  in  8  byte strobes; bit i enables wdata[8i+7:8i]
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready

## Operation
- Word index = (addr − BASE) >> 3. addr[2:0] is ignored; lane selection is the master's job.
- An address is in range iff BASE ≤ addr < BASE + DEPTH*8.
- The read and write FSMs are independent and may run concurrently.
- Read FSM, states R_IDLE → R_WAIT → R_RESP:
  - R_IDLE: arready=1. On arvalid, latch araddr, load counter with LATENCY, go to R_WAIT.
  - R_WAIT: decrement the counter. At 0, capture mem[index] into rdata with rresp=00. If out of range, rdata=0 and rresp=10. Go to R_RESP.
  - R_RESP: rvalid=1; rdata and rresp held stable. On rready, go to R_IDLE.
- Write FSM, states W_IDLE → W_WAIT → W_RESP:
  - W_IDLE: awready=1 until AW is latched; wready=1 until W is latched.
  - AW and W may arrive in either order or in the same cycle. Each is latched independently and its ready drops once captured.
  - With both latched, load the counter with LATENCY and go to W_WAIT.
  - W_WAIT: at counter 0, commit byte-masked wdata to mem[index] (in range only). bresp=00, or 10 if out of range. Go to W_RESP.
  - W_RESP: bvalid=1. On bready, go to W_IDLE, clear both latch flags, and reassert awready/wready.
- Read capture and write commit to the same word in the same cycle: the read returns the old data (read-before-write).
- wstrb=0 in range: no bytes change, bresp=00.
- Memory contents are not reset (simulation init is X or preloaded by the bench).

## Timing
- Reset (rst=0), asynchronous:
  - Outputs: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00.
  - FSMs go to IDLE; write latch flags clear.
- First rising edge after rst deasserts: arready=1, awready=1, wready=1.
- Read latency: AR handshake on edge T; rvalid rises after edge T+1+LATENCY. With LATENCY=0, rvalid is high in the cycle after the handshake.
- Write latency: last of AW/W accepted on edge T; bvalid rises after edge T+1+LATENCY. The memory commit is on that same edge.
- Valid outputs hold until their ready is seen. No new address is accepted on a channel while its FSM is busy: arready=0 outside R_IDLE, awready/wready=0 once latched.
- Back-to-back: after the rready handshake on edge T, arready=1 in the following cycle. Minimum read spacing is LATENCY+3 cycles.
- Reset asserted mid-transaction: the transaction is abandoned, valids drop immediately (asynchronous), and no memory write occurs unless the commit edge has already passed.

## Test plan
- Reset: hold rst=0 with arvalid=1 → arready, rvalid and bvalid all stay 0; after release, arready=1 on the next edge.
- Write then read, LATENCY=2:
  - Write awaddr=0x80000008, wdata=0x1122334455667788, wstrb=0xFF → bvalid exactly 3 cycles after the handshake, bresp=00.
  - Read of the same address → rdata=0x1122334455667788, rresp=00, rvalid 3 cycles after the AR handshake.
- Partial strobe: word holds 0xFFFFFFFFFFFFFFFF; write wdata=0, wstrb=0x0F → read returns 0xFFFFFFFF00000000.
- Out of range:
  - Read 0x7FFFFFF8 → rresp=10, rdata=0.
  - Write 0x80002000 (DEPTH=1024) → bresp=10; the array is unchanged (spot-check word 0).
- Channel ordering: W sent 4 cycles before AW → wready drops after W is taken and bvalid follows AW by LATENCY+1. Repeat with AW first and with both in the same cycle; the result is identical.
- Backpressure and concurrency:
  - Hold rready=0 for 10 cycles → rvalid and rdata stay stable and arready stays 0.
  - Concurrent read and write to the same word committing on the same edge → the read returns the old value, and a later read returns the new one.
